// File: rtl/instr_register_pkg.sv
// Shared types for the instruction register and its executor: opcodes, operands,
// slot addresses, the stored instruction word, the result type and the executor FSM states.
package instr_register_pkg;

    localparam int OPERAND_W        = 32;
    localparam int ADDRESS_W        = 5;
    localparam int NUM_SLOTS        = 32;
    localparam int RESULT_W_DEFAULT = 64;

    // Opcode codes 8..15 are unassigned; the executor flags them as errors.
    typedef enum logic [3:0] {
        ZERO  = 4'd0,
        PASSA = 4'd1,
        PASSB = 4'd2,
        ADD   = 4'd3,
        SUB   = 4'd4,
        MULT  = 4'd5,
        DIV   = 4'd6,
        MOD   = 4'd7
    } opcode_t;

    typedef logic signed [OPERAND_W-1:0] operand_t;
    typedef logic [ADDRESS_W-1:0]        address_t;

    typedef struct packed {
        opcode_t  opc;
        operand_t op_a;
        operand_t op_b;
    } instruction_t;

    typedef logic signed [RESULT_W_DEFAULT-1:0] result_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        OUT   = 2'd3
    } exec_state_t;

endpackage

// File: rtl/instr_alu.sv
// Combinational ALU for one instruction: operands are sign-extended to RESULT_W first.
// Define EXEC_DIV_EN to build the divider; without it DIV and MOD report an error.
module instr_alu
    import instr_register_pkg::*;
#(
    parameter int RESULT_W = RESULT_W_DEFAULT
) (
    input  opcode_t                     opcode,
    input  operand_t                    op_a,
    input  operand_t                    op_b,
    output logic signed [RESULT_W-1:0]  result,
    output logic                        err
);

    logic signed [RESULT_W-1:0] a_ext;
    logic signed [RESULT_W-1:0] b_ext;

    assign a_ext = {{(RESULT_W-OPERAND_W){op_a[OPERAND_W-1]}}, op_a};
    assign b_ext = {{(RESULT_W-OPERAND_W){op_b[OPERAND_W-1]}}, op_b};

    always_comb begin
        result = '0;
        err    = 1'b0;
        case (opcode)
            ZERO:  result = '0;
            PASSA: result = a_ext;
            PASSB: result = b_ext;
            ADD:   result = a_ext + b_ext;
            SUB:   result = a_ext - b_ext;
            // RESULT_W >= 2*OPERAND_W, so the low RESULT_W bits hold the full product.
            MULT:  result = a_ext * b_ext;
`ifdef EXEC_DIV_EN
            DIV: begin
                if (op_b == '0) err = 1'b1;
                else            result = a_ext / b_ext;
            end
            MOD: begin
                if (op_b == '0) err = 1'b1;
                else            result = a_ext % b_ext;
            end
`else
            DIV:   err = 1'b1;
            MOD:   err = 1'b1;
`endif
            default: err = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_executor.sv
// Walks a window of instr_register slots, executes each instruction through instr_alu
// and offers one registered result per instruction on a valid/ready handshake (EXEC_DIV_EN enables DIV/MOD).
module instr_executor
    import instr_register_pkg::*;
#(
    parameter int RESULT_W = RESULT_W_DEFAULT
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        start,
    input  address_t                    first_addr,
    input  logic [5:0]                  count,
    output address_t                    read_pointer,
    input  instruction_t                instruction_word,
    output logic                        busy,
    output logic                        result_valid,
    input  logic                        result_ready,
    output logic signed [RESULT_W-1:0]  result,
    output opcode_t                     result_opcode,
    output address_t                    result_addr,
    output logic                        result_err,
    output logic                        done
);

    // Handshake: a result transfers on any rising edge where result_valid and
    // result_ready are both high; while valid is high and ready low, every
    // result field holds. ready is ignored while valid is low.

    exec_state_t                state_q, state_d;
    address_t                   ptr_q, ptr_d;
    logic [5:0]                 remaining_q, remaining_d;
    instruction_t               instr_q, instr_d;
    logic signed [RESULT_W-1:0] result_q, result_d;
    opcode_t                    opc_q, opc_d;
    address_t                   addr_q, addr_d;
    logic                       err_q, err_d;
    logic                       valid_q, valid_d;
    logic                       done_q, done_d;

    logic signed [RESULT_W-1:0] alu_result;
    logic                       alu_err;
    logic                       handshake;

    instr_alu #(
        .RESULT_W (RESULT_W)
    ) u_alu (
        .opcode (instr_q.opc),
        .op_a   (instr_q.op_a),
        .op_b   (instr_q.op_b),
        .result (alu_result),
        .err    (alu_err)
    );

    assign handshake = valid_q && result_ready;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        remaining_d = remaining_q;
        instr_d     = instr_q;
        result_d    = result_q;
        opc_d       = opc_q;
        addr_d      = addr_q;
        err_d       = err_q;
        valid_d     = valid_q;
        done_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    ptr_d       = first_addr;
                    remaining_d = count;
                    if (count == 6'd0) done_d  = 1'b1;
                    else               state_d = FETCH;
                end
            end
            FETCH: begin
                instr_d = instruction_word;
                state_d = EXEC;
            end
            EXEC: begin
                result_d = alu_result;
                err_d    = alu_err;
                opc_d    = instr_q.opc;
                addr_d   = ptr_q;
                valid_d  = 1'b1;
                state_d  = OUT;
            end
            OUT: begin
                if (handshake) begin
                    valid_d     = 1'b0;
                    ptr_d       = ptr_q + 5'd1;
                    remaining_d = remaining_q - 6'd1;
                    if (remaining_q == 6'd1) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = FETCH;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            remaining_q <= '0;
            instr_q     <= '0;
            result_q    <= '0;
            opc_q       <= ZERO;
            addr_q      <= '0;
            err_q       <= 1'b0;
            valid_q     <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            remaining_q <= remaining_d;
            instr_q     <= instr_d;
            result_q    <= result_d;
            opc_q       <= opc_d;
            addr_q      <= addr_d;
            err_q       <= err_d;
            valid_q     <= valid_d;
            done_q      <= done_d;
        end
    end

    // ptr only moves on a handshake or a start, so the address is stable through FETCH.
    assign read_pointer  = ptr_q;
    assign busy          = (state_q != IDLE);
    assign result_valid  = valid_q;
    assign result        = result_q;
    assign result_opcode = opc_q;
    assign result_addr   = addr_q;
    assign result_err    = err_q;
    assign done          = done_q;

endmodule

// File: tb/tb_instr_executor.sv
// Directed bench for instr_executor: a slot array models instr_register, and each
// result is compared with a hand-computed value.
module tb_instr_executor;
    import instr_register_pkg::*;

    logic                 clk = 1'b0;
    logic                 reset_n = 1'b0;
    logic                 start = 1'b0;
    address_t             first_addr = '0;
    logic [5:0]           count = '0;
    address_t             read_pointer;
    instruction_t         instruction_word;
    logic                 busy;
    logic                 result_valid;
    logic                 result_ready = 1'b0;
    result_t              result;
    opcode_t              result_opcode;
    address_t             result_addr;
    logic                 result_err;
    logic                 done;

    instruction_t         mem [NUM_SLOTS];

    int n_checks = 0;
    int n_pass   = 0;

`ifdef EXEC_DIV_EN
    localparam logic [63:0] EXP_DIV_M7_2 = -64'sd3;
    localparam logic [63:0] EXP_MOD_M7_2 = -64'sd1;
    localparam logic [63:0] EXP_DIV_8_2  = 64'sd4;
    localparam logic        EXP_DIV_ERR  = 1'b0;
`else
    localparam logic [63:0] EXP_DIV_M7_2 = 64'sd0;
    localparam logic [63:0] EXP_MOD_M7_2 = 64'sd0;
    localparam logic [63:0] EXP_DIV_8_2  = 64'sd0;
    localparam logic        EXP_DIV_ERR  = 1'b1;
`endif

    always #5 clk = ~clk;

    assign instruction_word = mem[read_pointer];

    instr_executor #(
        .RESULT_W (64)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .start            (start),
        .first_addr       (first_addr),
        .count            (count),
        .read_pointer     (read_pointer),
        .instruction_word (instruction_word),
        .busy             (busy),
        .result_valid     (result_valid),
        .result_ready     (result_ready),
        .result           (result),
        .result_opcode    (result_opcode),
        .result_addr      (result_addr),
        .result_err       (result_err),
        .done             (done)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic set_slot(input int addr, input opcode_t opc, input operand_t a, input operand_t b);
        mem[addr].opc  = opc;
        mem[addr].op_a = a;
        mem[addr].op_b = b;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".read_pointer"},  64'(read_pointer), 64'd0);
        check({tag, ".busy"},          64'(busy), 64'd0);
        check({tag, ".result_valid"},  64'(result_valid), 64'd0);
        check({tag, ".result"},        result, 64'd0);
        check({tag, ".result_opcode"}, 64'(result_opcode), 64'd0);
        check({tag, ".result_addr"},   64'(result_addr), 64'd0);
        check({tag, ".result_err"},    64'(result_err), 64'd0);
        check({tag, ".done"},          64'(done), 64'd0);
    endtask

    // Called at a negedge; returns at the following negedge (the FETCH cycle).
    task automatic pulse_start(input address_t a, input logic [5:0] c);
        first_addr = a;
        count      = c;
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
    endtask

    // Entered during FETCH; returns at the negedge where result_valid is first seen.
    task automatic expect_result(input string tag, input address_t addr, input opcode_t opc,
                                 input logic [63:0] res, input logic err);
        int cyc = 0;
        check({tag, ".read_pointer"}, 64'(read_pointer), 64'(addr));
        while (!result_valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, ".latency"},       64'(cyc), 64'd2);
        check({tag, ".result"},        result, res);
        check({tag, ".result_err"},    64'(result_err), 64'(err));
        check({tag, ".result_opcode"}, 64'(result_opcode), 64'(opc));
        check({tag, ".result_addr"},   64'(result_addr), 64'(addr));
        check({tag, ".done_low"},      64'(done), 64'd0);
    endtask

    // Entered at the negedge before the final handshake edge (result_ready high).
    task automatic expect_done(input string tag);
        @(negedge clk);
        check({tag, ".done"},       64'(done), 64'd1);
        check({tag, ".busy"},       64'(busy), 64'd0);
        @(negedge clk);
        check({tag, ".done_clear"}, 64'(done), 64'd0);
        check({tag, ".busy_idle"},  64'(busy), 64'd0);
    endtask

    initial begin
        for (int i = 0; i < NUM_SLOTS; i++) set_slot(i, ZERO, 0, 0);

        // Reset state
        @(negedge clk);
        check_all_zero("reset");
        reset_n = 1'b1;
        @(negedge clk);

        // Single ADD, ready held high
        set_slot(0, ADD, 5, 7);
        result_ready = 1'b1;
        pulse_start(5'd0, 6'd1);
        expect_result("add", 5'd0, ADD, 64'sd12, 1'b0);
        expect_done("add");

        // Window wrapping 30, 31, 0
        set_slot(30, SUB, 3, 10);
        set_slot(31, MULT, -4, 32'sh7FFFFFFF);
        set_slot(0, PASSB, 0, -9);
        pulse_start(5'd30, 6'd3);
        expect_result("sub", 5'd30, SUB, -64'sd7, 1'b0);
        @(negedge clk);
        expect_result("mult", 5'd31, MULT, -64'sd8589934588, 1'b0);
        @(negedge clk);
        expect_result("passb", 5'd0, PASSB, -64'sd9, 1'b0);
        expect_done("wrap");

        // Division family, illegal opcode, ZERO and PASSA
        set_slot(1, DIV, -7, 2);
        set_slot(2, MOD, -7, 2);
        set_slot(3, DIV, 5, 0);
        set_slot(4, DIV, 8, 2);
        set_slot(5, opcode_t'(4'hF), 1, 2);
        set_slot(6, ZERO, 3, 4);
        set_slot(7, PASSA, -5, 9);
        pulse_start(5'd1, 6'd7);
        expect_result("div_neg", 5'd1, DIV, EXP_DIV_M7_2, EXP_DIV_ERR);
        @(negedge clk);
        expect_result("mod_neg", 5'd2, MOD, EXP_MOD_M7_2, EXP_DIV_ERR);
        @(negedge clk);
        expect_result("div_zero", 5'd3, DIV, 64'sd0, 1'b1);
        @(negedge clk);
        expect_result("div_8_2", 5'd4, DIV, EXP_DIV_8_2, EXP_DIV_ERR);
        @(negedge clk);
        expect_result("illegal", 5'd5, opcode_t'(4'hF), 64'sd0, 1'b1);
        @(negedge clk);
        expect_result("zero", 5'd6, ZERO, 64'sd0, 1'b0);
        @(negedge clk);
        expect_result("passa", 5'd7, PASSA, -64'sd5, 1'b0);
        expect_done("alu");

        // Back-pressure with a stray start mid-run
        set_slot(10, ADD, 100, -1);
        set_slot(11, PASSA, -3, 0);
        set_slot(20, ADD, 1000, 1000);
        result_ready = 1'b0;
        pulse_start(5'd10, 6'd2);
        expect_result("hold", 5'd10, ADD, 64'sd99, 1'b0);
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                first_addr = 5'd20;
                count      = 6'd1;
                start      = 1'b1;
            end
            if (i == 4) start = 1'b0;
            @(negedge clk);
            check("hold.result",       result, 64'sd99);
            check("hold.result_valid", 64'(result_valid), 64'd1);
            check("hold.read_pointer", 64'(read_pointer), 64'd10);
            check("hold.result_addr",  64'(result_addr), 64'd10);
        end
        result_ready = 1'b1;
        @(negedge clk);
        expect_result("hold_next", 5'd11, PASSA, -64'sd3, 1'b0);
        expect_done("hold");
        @(negedge clk);
        check("hold.no_queued_start", 64'(busy), 64'd0);

        // Asynchronous reset while a result is waiting
        set_slot(12, ADD, 1, 1);
        result_ready = 1'b0;
        pulse_start(5'd12, 6'd1);
        expect_result("pre_reset", 5'd12, ADD, 64'sd2, 1'b0);
        reset_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check_all_zero("post_reset");

        // count = 0: done one cycle after the start edge, no result
        result_ready = 1'b1;
        pulse_start(5'd3, 6'd0);
        check("count0.done",  64'(done), 64'd1);
        check("count0.busy",  64'(busy), 64'd0);
        check("count0.valid", 64'(result_valid), 64'd0);
        @(negedge clk);
        check("count0.done_clear", 64'(done), 64'd0);
        check("count0.valid_low",  64'(result_valid), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/instr_executor.md
# instr_executor

Downstream consumer of instr_register. On a start pulse it walks a window of register slots via read_pointer, captures each instruction_word, executes the opcode on the two signed operands, and presents one registered result per instruction on a valid/ready handshake. It sits beside the testbench in top, sharing clk and reset_n with the register.

## Interface
Parameters:
- RESULT_W, 64: result width; must be at least 2× operand width.

Ports:
- clk  in  1  system clock, rising-edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle request; accepted only in IDLE.
- first_addr  in  address_t  first slot to execute.
- count  in  6  number of instructions, 0..32.
- read_pointer  out  address_t  slot address driven to instr_register.
- instruction_word  in  instruction_t  combinational read data for read_pointer.
- busy  out  1  high in any state other than IDLE.
- result_valid  out  1  result fields valid.
- result_ready  in  1  consumer accepts the result.
- result  out  RESULT_W  signed result.
- result_opcode  out  opcode_t  opcode that produced the result.
- result_addr  out  address_t  source slot.
- result_err  out  1  divide-by-zero, or an opcode that is illegal or disabled.
- done  out  1  one-cycle pulse after the last result is accepted.

## Operation
- FSM states: IDLE, FETCH, EXEC, OUT.
- **IDLE, start=1:**
  - Latch ptr=first_addr and remaining=count.
  - count=0: go to IDLE and pulse done next cycle; no results are produced.
  - Otherwise: go to FETCH.
- **FETCH:** read_pointer=ptr. Register instruction_word at the clock edge, then go to EXEC.
- **EXEC:** compute from the captured word, register the result fields, assert result_valid, then go to OUT.
- **OUT:** hold all result fields stable while result_valid=1 and result_ready=0. On a handshake (valid && ready):
  - ptr increments modulo 32; it wraps 31→0.
  - remaining decrements.
  - remaining reaching 0: go to IDLE and pulse done. Otherwise: go to FETCH.
- **Arithmetic:** operands are sign-extended to RESULT_W before the operation.
  - ZERO: 0.
  - PASSA: a. PASSB: b.
  - ADD: a+b. SUB: a−b. MULT: a*b, full 64-bit product.
  - DIV: truncates toward zero. MOD: remainder takes the sign of the dividend.
- **Errors:**
  - DIV or MOD with b=0: result=0, result_err=1.
  - Opcode outside the enum: result=0, result_err=1.
  - result_err=0 otherwise.
- start while busy is ignored; no queuing.
- result_ready while result_valid=0 is ignored.
- **Reset (asynchronous, including mid-operation):** state=IDLE. All outputs are 0: read_pointer, busy, result_valid, result, result_opcode (ZERO), result_addr, result_err, done. ptr and remaining are also 0. An in-flight result is discarded.

## Timing
- start at edge T: FETCH during cycle T+1, EXEC T+2, result_valid high from T+3.
- Best-case throughput: one instruction per 3 cycles, with result_ready held high.
- read_pointer is stable throughout FETCH. instruction_word must settle within that cycle, because the register read is combinational.
- done is high for exactly one cycle, the cycle after the final handshake edge. busy deasserts in that same cycle.
- With count=0, done follows the start edge by one cycle.

## Configuration
- **EXEC_DIV_EN defined:** DIV and MOD are implemented as described above.
- **EXEC_DIV_EN undefined:** no divider is synthesised. DIV and MOD return result=0 with result_err=1; all other opcodes are unchanged.

## Structure
- instr_register_pkg:
  - Already holds opcode_t, operand_t, address_t, instruction_t.
  - Add result_t (signed [RESULT_W-1:0]) and exec_state_t (the FSM enum).
- One sub-module: instr_alu.
  - Purely combinational.
  - Inputs: opcode, op_a, op_b. Outputs: result, err.
  - Holds the EXEC_DIV_EN guard.
- instr_executor holds the FSM, pointer/count registers and output registers.

## Test plan
- Load slot 0 = ADD 5,7; start first_addr=0 count=1, result_ready=1 → result=12, result_err=0, result_addr=0; done pulses 1 cycle after handshake.
- Slots 30,31,0 = SUB 3,10 / MULT −4,0x7FFFFFFF / PASSB 0,−9; start first_addr=30 count=3 → results −7, −8589934588, −9. read_pointer order 30,31,0.
- DIV −7,2 then MOD −7,2 → −3 then −1. DIV 5,0 → result=0, result_err=1. Without EXEC_DIV_EN, DIV 8,2 → result=0, result_err=1.
- Hold result_ready=0 for 10 cycles → result and result_valid stay stable; pulse start mid-run → ignored; read_pointer does not advance.
- Assert reset_n=0 while in OUT with result_valid=1 → all outputs 0 immediately; a subsequent start with count=0 → done one cycle later, result_valid never asserted.
